// File: rtl/sram_banked_arb.sv
// Two-port scratchpad built from N_BANKS word-interleaved single-port banks.
// Per-bank round-robin arbitration, selectable write-response mode, saturating conflict counter.
module sram_banked_arb #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N_ENTRIES  = 4096,
    parameter int unsigned N_BANKS    = 4,
    parameter int unsigned WRITE_MODE = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req1_i,
    input  logic                          we1_i,
    input  logic [DATA_WIDTH/8-1:0]       be1_i,
    input  logic [$clog2(N_ENTRIES)-1:0]  addr1_i,
    input  logic [DATA_WIDTH-1:0]         data1_i,
    input  logic                          req2_i,
    input  logic                          we2_i,
    input  logic [DATA_WIDTH/8-1:0]       be2_i,
    input  logic [$clog2(N_ENTRIES)-1:0]  addr2_i,
    input  logic [DATA_WIDTH-1:0]         data2_i,
    output logic                          gnt1_o,
    output logic [DATA_WIDTH-1:0]         data1_o,
    output logic                          ready1_o,
    output logic                          gnt2_o,
    output logic [DATA_WIDTH-1:0]         data2_o,
    output logic                          ready2_o,
    output logic [31:0]                   conflict_cnt_o
);
    localparam int unsigned AW   = $clog2(N_ENTRIES);
    localparam int unsigned BW   = $clog2(N_BANKS);
    localparam int unsigned BWE  = (BW > 0) ? BW : 1;
    localparam int unsigned ROWS = N_ENTRIES / N_BANKS;
    localparam int unsigned RW   = (AW > BW) ? (AW - BW) : 1;
    localparam int unsigned NB   = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [N_BANKS][ROWS];
    logic [N_BANKS-1:0]    r_ptr;
    logic [31:0]           r_conflict_cnt;
    logic                  r_ready1, r_ready2;
    logic [DATA_WIDTH-1:0] r_data1, r_data2;

    logic [BWE-1:0]        w_bank1, w_bank2;
    logic [RW-1:0]         w_row1, w_row2;
    logic                  w_contest, w_ptr;
    logic                  w_wr1, w_wr2;
    logic [DATA_WIDTH-1:0] w_old1, w_old2, w_merged1, w_merged2, w_resp1, w_resp2;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [NB-1:0]         be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_w;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
        end
        return res;
    endfunction

    // Low address bits pick the bank; a single bank has no select field
    generate
        if (BW > 0) begin : g_bank
            assign w_bank1 = addr1_i[BWE-1:0];
            assign w_bank2 = addr2_i[BWE-1:0];
        end else begin : g_nobank
            assign w_bank1 = 1'b0;
            assign w_bank2 = 1'b0;
        end
    endgenerate

    assign w_row1 = RW'(addr1_i >> BW);
    assign w_row2 = RW'(addr2_i >> BW);

    assign w_contest = req1_i & req2_i & (w_bank1 == w_bank2);
    assign w_ptr     = r_ptr[w_bank1];
    assign gnt1_o    = ~rst_i & req1_i & (~w_contest | ~w_ptr);
    assign gnt2_o    = ~rst_i & req2_i & (~w_contest | w_ptr);

    assign w_wr1     = gnt1_o & we1_i;
    assign w_wr2     = gnt2_o & we2_i;
    assign w_old1    = r_mem[w_bank1][w_row1];
    assign w_old2    = r_mem[w_bank2][w_row2];
    assign w_merged1 = merge_bytes(w_old1, data1_i, be1_i);
    assign w_merged2 = merge_bytes(w_old2, data2_i, be2_i);
    assign w_resp1   = ((WRITE_MODE != 0) && we1_i) ? w_merged1 : w_old1;
    assign w_resp2   = ((WRITE_MODE != 0) && we2_i) ? w_merged2 : w_old2;

    // Arbitration guarantees the two ports never write the same bank in one cycle
    always_ff @(posedge clk_i) begin
        if (w_wr1) r_mem[w_bank1][w_row1] <= w_merged1;
        if (w_wr2) r_mem[w_bank2][w_row2] <= w_merged2;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ready1 <= 1'b0;
            r_ready2 <= 1'b0;
            r_data1  <= '0;
            r_data2  <= '0;
        end else begin
            r_ready1 <= gnt1_o;
            r_ready2 <= gnt2_o;
            if (gnt1_o) r_data1 <= w_resp1;
            if (gnt2_o) r_data2 <= w_resp2;
        end
    end

    // Contested bank pointer flips toward the loser; counter saturates
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr          <= '0;
            r_conflict_cnt <= '0;
        end else if (w_contest) begin
            r_ptr[w_bank1] <= gnt1_o;
            if (r_conflict_cnt != '1) r_conflict_cnt <= r_conflict_cnt + 32'd1;
        end
    end

    assign data1_o        = r_data1;
    assign data2_o        = r_data2;
    assign ready1_o       = r_ready1;
    assign ready2_o       = r_ready2;
    assign conflict_cnt_o = r_conflict_cnt;

endmodule
